// File: rtl/jamma_pkg.sv
// Shared definitions for the JAMMA input scanner: scan FSM states,
// JAMMA bit positions and the released (all-high) bus value.
package jamma_pkg;

  // Scan sequencer states; P1_* drive jselect low, P2_* drive it high.
  typedef enum logic [1:0] {
    P1_SETTLE = 2'd0,
    P1_SAMPLE = 2'd1,
    P2_SETTLE = 2'd2,
    P2_SAMPLE = 2'd3
  } scan_state_t;

  // Bit positions on the JAMMA player word (active-low).
  localparam int UP    = 0;
  localparam int DOWN  = 1;
  localparam int LEFT  = 2;
  localparam int RIGHT = 3;
  localparam int B1    = 4;
  localparam int B2    = 5;
  localparam int B3    = 6;
  localparam int START = 7;

  // Value of a player word with nothing pressed.
  localparam logic [7:0] JAMMA_RELEASED = 8'hFF;

  localparam int NUM_COINS = 2;

endpackage

// File: rtl/jamma_debounce_bit.sv
// Single-bit scan-rate debouncer. The output follows the raw input only
// after DEBOUNCE_LEN consecutive enabled samples disagree with it.
module jamma_debounce_bit #(
  parameter int DEBOUNCE_LEN = 8
) (
  input  logic pclk,
  input  logic reset_n,
  input  logic sample_en,
  input  logic raw,
  output logic q
);

  localparam int            CW       = $clog2(DEBOUNCE_LEN + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_LEN - 1);

  logic [CW-1:0] cnt;

  // Count disagreeing samples; the sample that completes the run flips q
  // and clears the count together, so the counter never exceeds the limit.
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
      q   <= 1'b1;
    end else if (sample_en) begin
      if (raw == q) begin
        cnt <= '0;
      end else if (cnt >= CNT_LAST) begin
        q   <= raw;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/jamma_input_scanner.sv
// JAMMA multiplexed input scanner: alternates jselect between players,
// samples each half after a settle window, debounces every bit at scan
// rate and stretches coin pulses to a minimum width.
module jamma_input_scanner
  import jamma_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int DEBOUNCE_LEN  = 8,
  parameter int COIN_HOLD     = 16
) (
  input  logic       pclk,
  input  logic       reset_n,
  input  logic [7:0] jjoy,
  input  logic [1:0] jcoin,
  input  logic [5:0] joy_local,
  output logic       jselect,
  output logic [7:0] joystick1,
  output logic [7:0] joystick2,
  output logic [1:0] coin,
  output logic       scan_valid
);

  localparam int         SYNC_W      = 16;
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam int         HW          = $clog2(COIN_HOLD + 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(COIN_HOLD);

  scan_state_t   state;
  logic [7:0]    settle_cnt;

  logic [SYNC_W-1:0] sync_s0;
  logic [SYNC_W-1:0] sync_s1;
  logic [7:0]        jjoy_s;
  logic [5:0]        local_s;
  logic [1:0]        jcoin_s;

  logic [7:0]    p1_raw;
  logic          p1_sample;
  logic          p2_sample;

  logic [1:0]          coin_db;
  logic [1:0]          coin_prev;
  logic [1:0][HW-1:0]  hold;

  // Hold counter after one scan tick, floored at zero.
  function automatic logic [HW-1:0] hold_dec(input logic [HW-1:0] h);
    return (h != '0) ? h - 1'b1 : '0;
  endfunction

  // Two-flop synchronizer for every asynchronous input; released value is 1.
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      sync_s0 <= '1;
      sync_s1 <= '1;
    end else begin
      sync_s0 <= {jcoin, joy_local, jjoy};
      sync_s1 <= sync_s0;
    end
  end

  assign jjoy_s  = sync_s1[7:0];
  assign local_s = sync_s1[13:8];
  assign jcoin_s = sync_s1[15:14];

  // Scan sequencer: settle window then one sample clock per player.
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= P1_SETTLE;
      settle_cnt <= '0;
      jselect    <= 1'b0;
      scan_valid <= 1'b0;
    end else begin
      scan_valid <= 1'b0;
      case (state)
        P1_SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            settle_cnt <= '0;
            state      <= P1_SAMPLE;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        P1_SAMPLE: begin
          state   <= P2_SETTLE;
          jselect <= 1'b1;
        end
        P2_SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            settle_cnt <= '0;
            state      <= P2_SAMPLE;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        P2_SAMPLE: begin
          state      <= P1_SETTLE;
          jselect    <= 1'b0;
          scan_valid <= 1'b1;
        end
        default: begin
          state      <= P1_SETTLE;
          settle_cnt <= '0;
          jselect    <= 1'b0;
        end
      endcase
    end
  end

  assign p1_sample = (state == P1_SAMPLE);
  assign p2_sample = (state == P2_SAMPLE);

  // P1 word: the local DB9 stick is wired-AND onto the direction and
  // first two button bits; B3 and START come only from the harness.
  always_comb begin
    p1_raw         = JAMMA_RELEASED;
    p1_raw[B2:UP]  = jjoy_s[B2:UP] & local_s;
    p1_raw[B3]     = jjoy_s[B3];
    p1_raw[START]  = jjoy_s[START];
  end

  for (genvar i = 0; i < 8; i++) begin : g_p1
    jamma_debounce_bit #(.DEBOUNCE_LEN(DEBOUNCE_LEN)) u_db (
      .pclk      (pclk),
      .reset_n   (reset_n),
      .sample_en (p1_sample),
      .raw       (p1_raw[i]),
      .q         (joystick1[i])
    );
  end

  for (genvar i = 0; i < 8; i++) begin : g_p2
    jamma_debounce_bit #(.DEBOUNCE_LEN(DEBOUNCE_LEN)) u_db (
      .pclk      (pclk),
      .reset_n   (reset_n),
      .sample_en (p2_sample),
      .raw       (jjoy_s[i]),
      .q         (joystick2[i])
    );
  end

  for (genvar i = 0; i < NUM_COINS; i++) begin : g_coin
    jamma_debounce_bit #(.DEBOUNCE_LEN(DEBOUNCE_LEN)) u_db (
      .pclk      (pclk),
      .reset_n   (reset_n),
      .sample_en (p2_sample),
      .raw       (jcoin_s[i]),
      .q         (coin_db[i])
    );
  end

  // Coin stretch bookkeeping, ticked once per scan on the scan_valid clock
  // (the clock in which the debounced coin for that scan first appears).
  // A falling edge loads the hold only if the hold would otherwise expire.
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      coin_prev <= 2'b11;
      hold      <= '0;
    end else if (scan_valid) begin
      for (int i = 0; i < NUM_COINS; i++) begin
        coin_prev[i] <= coin_db[i];
        if (coin_prev[i] && !coin_db[i] && (hold_dec(hold[i]) == '0)) begin
          hold[i] <= HOLD_LOAD;
        end else begin
          hold[i] <= hold_dec(hold[i]);
        end
      end
    end
  end

  // Stretched coin: during the scan_valid clock the hold has not ticked yet,
  // so look at its post-tick value to keep coin aligned with joystick2.
  always_comb begin
    coin = 2'b11;
    for (int i = 0; i < NUM_COINS; i++) begin
      coin[i] = coin_db[i] &
                (((scan_valid != 1'b0) ? hold_dec(hold[i]) : hold[i]) == '0);
    end
  end

endmodule

// File: tb/tb_jamma_input_scanner.sv
// Self-checking bench for jamma_input_scanner: a behavioural harness mux
// drives jjoy from jselect (with garbage right after each switch), and a
// per-scan history model predicts the debounced and stretched outputs.
module tb_jamma_input_scanner;

  localparam int SETTLE    = 4;
  localparam int DLEN      = 8;
  localparam int CHOLD     = 16;
  localparam int SCAN_CLKS = 2 * (SETTLE + 1);

  logic       pclk    = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] jjoy;
  logic [1:0] jcoin;
  logic [5:0] joy_local;
  logic       jselect;
  logic [7:0] joystick1;
  logic [7:0] joystick2;
  logic [1:0] coin;
  logic       scan_valid;

  logic [7:0] p1_vec;
  logic [7:0] p2_vec;
  logic [7:0] garbage = 8'h00;
  logic       jsel_d  = 1'b0;

  int vec_cnt = 0;
  int err_cnt = 0;

  // Reference model state: raw history per scan since reset.
  logic [17:0] mq;
  int          last_chg [18];
  logic [17:0] hist [$];
  int          hold_until [2];

  jamma_input_scanner #(
    .SETTLE_CYCLES (SETTLE),
    .DEBOUNCE_LEN  (DLEN),
    .COIN_HOLD     (CHOLD)
  ) dut (
    .pclk       (pclk),
    .reset_n    (reset_n),
    .jjoy       (jjoy),
    .jcoin      (jcoin),
    .joy_local  (joy_local),
    .jselect    (jselect),
    .joystick1  (joystick1),
    .joystick2  (joystick2),
    .coin       (coin),
    .scan_valid (scan_valid)
  );

  always #5 pclk = ~pclk;

  // Harness mux: one clock of noise after every jselect change.
  always @(posedge pclk) begin
    jsel_d  <= jselect;
    garbage <= 8'($urandom);
  end

  assign jjoy = (jselect != jsel_d) ? garbage : (jselect ? p2_vec : p1_vec);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq = '1;
    for (int b = 0; b < 18; b++) last_chg[b] = -1;
    hist.delete();
    hold_until[0] = 0;
    hold_until[1] = 0;
  endtask

  // A bit flips once the last DLEN samples since its previous change all
  // disagree with it. Coins: a falling edge outside an active hold opens a
  // CHOLD-scan window during which the output stays low.
  task automatic model_step(input logic [17:0] raw);
    logic [17:0] prev;
    logic [17:0] w;
    int          n;
    bit          all_diff;
    prev = mq;
    hist.push_back(raw);
    n = hist.size() - 1;
    for (int b = 0; b < 18; b++) begin
      if (n - last_chg[b] >= DLEN) begin
        all_diff = 1'b1;
        for (int k = 0; k < DLEN; k++) begin
          w = hist[n - k];
          if (w[b] == mq[b]) all_diff = 1'b0;
        end
        if (all_diff) begin
          mq[b]       = raw[b];
          last_chg[b] = n;
        end
      end
    end
    for (int c = 0; c < 2; c++) begin
      if (prev[16+c] && !mq[16+c] && (n >= hold_until[c])) hold_until[c] = n + CHOLD;
    end
  endtask

  task automatic check_scan_outputs();
    int          n;
    logic [1:0]  exp_coin;
    n = hist.size() - 1;
    for (int c = 0; c < 2; c++) exp_coin[c] = mq[16+c] && (n >= hold_until[c]);
    chk("joystick1", 32'(joystick1), 32'(mq[7:0]));
    chk("joystick2", 32'(joystick2), 32'(mq[15:8]));
    chk("coin", 32'(coin), 32'(exp_coin));
    chk("jselect_at_scan_valid", 32'(jselect), 32'd0);
  endtask

  // Wait for the next scan_valid, check its spacing, then score the scan.
  task automatic do_scan(input int exp_cyc);
    int cyc;
    cyc = 0;
    do begin
      @(negedge pclk);
      cyc++;
    end while (!scan_valid && cyc < 4 * SCAN_CLKS);
    chk("scan_period", 32'(cyc), 32'(exp_cyc));
    model_step({jcoin, p2_vec, p1_vec & {2'b11, joy_local}});
    check_scan_outputs();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_jselect"}, 32'(jselect), 32'd0);
    chk({tag, "_joystick1"}, 32'(joystick1), 32'hFF);
    chk({tag, "_joystick2"}, 32'(joystick2), 32'hFF);
    chk({tag, "_coin"}, 32'(coin), 32'h3);
    chk({tag, "_scan_valid"}, 32'(scan_valid), 32'd0);
  endtask

  // Release reset and time the first P1 sample via the jselect rise.
  task automatic release_reset();
    int cyc;
    model_reset();
    reset_n = 1'b1;
    cyc = 0;
    do begin
      @(negedge pclk);
      cyc++;
    end while (!jselect && cyc < 4 * SCAN_CLKS);
    chk("first_p1_sample", 32'(cyc), 32'(SETTLE + 1));
    do_scan(SCAN_CLKS - (SETTLE + 1));
  endtask

  initial begin
    int cyc;
    int r;
    p1_vec    = '1;
    p2_vec    = '1;
    jcoin     = '1;
    joy_local = '1;

    reset_n = 1'b0;
    repeat (3) @(negedge pclk);
    check_reset_outputs("reset");
    release_reset();

    // Idle: everything released.
    repeat (19) do_scan(SCAN_CLKS);

    // P1 bit0 held low, then released.
    p1_vec[0] = 1'b0;
    repeat (12) do_scan(SCAN_CLKS);
    p1_vec[0] = 1'b1;
    repeat (10) do_scan(SCAN_CLKS);

    // Bit3: runs of 7 never pass, a run of 8 does.
    for (int rep = 0; rep < 3; rep++) begin
      p1_vec[3] = 1'b0;
      repeat (7) do_scan(SCAN_CLKS);
      p1_vec[3] = 1'b1;
      repeat (7) do_scan(SCAN_CLKS);
    end
    p1_vec[3] = 1'b0;
    repeat (8) do_scan(SCAN_CLKS);
    p1_vec[3] = 1'b1;
    repeat (10) do_scan(SCAN_CLKS);

    // Coin0: press, release, press again right as the hold expires.
    jcoin[0] = 1'b0;
    repeat (8) do_scan(SCAN_CLKS);
    jcoin[0] = 1'b1;
    repeat (8) do_scan(SCAN_CLKS);
    jcoin[0] = 1'b0;
    repeat (8) do_scan(SCAN_CLKS);
    jcoin[0] = 1'b1;
    repeat (30) do_scan(SCAN_CLKS);

    // Local stick merged into P1 only.
    joy_local = 6'b111011;
    repeat (12) do_scan(SCAN_CLKS);
    joy_local = '1;
    repeat (10) do_scan(SCAN_CLKS);

    // P2 pattern held long enough to debounce.
    p2_vec = 8'h5A;
    jcoin[1] = 1'b0;
    repeat (10) do_scan(SCAN_CLKS);
    p2_vec = '1;
    jcoin[1] = 1'b1;
    repeat (10) do_scan(SCAN_CLKS);

    // Random slow-changing inputs.
    for (int i = 0; i < 120; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        r = $urandom_range(0, 23);
        if (r < 8)       p1_vec[r]         = ~p1_vec[r];
        else if (r < 16) p2_vec[r-8]       = ~p2_vec[r-8];
        else if (r < 22) joy_local[r-16]   = ~joy_local[r-16];
        else             jcoin[r-22]       = ~jcoin[r-22];
      end
      do_scan(SCAN_CLKS);
    end

    // Mid-scan reset with joystick1 showing bit0 pressed.
    p1_vec = '1; p2_vec = '1; jcoin = '1; joy_local = '1;
    repeat (30) do_scan(SCAN_CLKS);
    p1_vec[0] = 1'b0;
    repeat (9) do_scan(SCAN_CLKS);
    chk("pre_reset_joystick1", 32'(joystick1), 32'hFE);
    cyc = 0;
    do begin
      @(negedge pclk);
      cyc++;
    end while (!jselect && cyc < 4 * SCAN_CLKS);
    chk("reached_p2_settle", 32'(jselect), 32'd1);
    @(negedge pclk);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midscan_reset");
    repeat (2) @(negedge pclk);
    release_reset();
    repeat (11) do_scan(SCAN_CLKS);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
